// File: rtl/pacman_pkg.sv
// Shared encodings for the Pacman controller and datapath: FSM states,
// joystick codes, register select codes and the default screen extent.
package pacman_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_DRAW,
        ST_LOAD_T,
        ST_WAIT,
        ST_ERASE,
        ST_TURN,
        ST_MOVE
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [1:0] SEL_POS_LOAD = 2'd0;
    localparam logic [1:0] SEL_POS_INC  = 2'd1;
    localparam logic [1:0] SEL_POS_DEC  = 2'd2;
    localparam logic [1:0] SEL_POS_HOLD = 2'd3;

    localparam logic [1:0] SEL_DIR_DEFAULT = 2'd0;
    localparam logic [1:0] SEL_DIR_INPUT   = 2'd1;

    localparam logic [1:0] SEL_TMR_LOAD = 2'd0;
    localparam logic [1:0] SEL_TMR_DEC  = 2'd1;

    localparam logic [1:0] COL_BLACK  = 2'd0;
    localparam logic [1:0] COL_PACMAN = 2'd1;
    localparam logic [1:0] COL_BG     = 2'd2;

    localparam logic [7:0] PKG_X_MAX = 8'd159;
    localparam logic [6:0] PKG_Y_MAX = 7'd119;

endpackage

// File: rtl/pacman_controller.sv
// Frame sequencer for the Pacman datapath: draw, wait on timer, erase, latch
// joystick, step one pixel with edge clamping. Outputs decode from registered state.
module pacman_controller
    import pacman_pkg::*;
#(
    parameter logic [7:0] X_MAX = PKG_X_MAX,
    parameter logic [6:0] Y_MAX = PKG_Y_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startGame,
    input  logic [1:0] direction,
    input  logic       timer_done,
    input  logic [7:0] x_pos,
    input  logic [6:0] y_pos,
    output logic       en_x_position,
    output logic [1:0] s_x_position,
    output logic       en_y_position,
    output logic [1:0] s_y_position,
    output logic       en_direction,
    output logic [1:0] s_direction,
    output logic       en_timer,
    output logic [1:0] s_timer,
    output logic [1:0] s_plot_color,
    output logic       plot
);

    state_t     r_state;
    state_t     w_next;
    logic [1:0] r_dir_q;

    logic w_at_left;
    logic w_at_right;
    logic w_at_top;
    logic w_at_bottom;

    assign w_at_left   = (x_pos == 8'd0);
    assign w_at_right  = (x_pos >= X_MAX);
    assign w_at_top    = (y_pos == 7'd0);
    assign w_at_bottom = (y_pos >= Y_MAX);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_dir_q <= DIR_RIGHT;
        end else begin
            r_state <= w_next;
            if (r_state == ST_INIT) begin
                r_dir_q <= DIR_RIGHT;
            end else if (r_state == ST_TURN) begin
                r_dir_q <= direction;
            end
        end
    end

    always_comb begin
        w_next        = r_state;
        en_x_position = 1'b0;
        s_x_position  = SEL_POS_LOAD;
        en_y_position = 1'b0;
        s_y_position  = SEL_POS_LOAD;
        en_direction  = 1'b0;
        s_direction   = SEL_DIR_DEFAULT;
        en_timer      = 1'b0;
        s_timer       = SEL_TMR_LOAD;
        s_plot_color  = COL_BLACK;
        plot          = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (startGame) w_next = ST_INIT;
            end
            ST_INIT: begin
                en_x_position = 1'b1;
                en_y_position = 1'b1;
                en_direction  = 1'b1;
                w_next        = ST_DRAW;
            end
            ST_DRAW: begin
                plot         = 1'b1;
                s_plot_color = COL_PACMAN;
                w_next       = ST_LOAD_T;
            end
            ST_LOAD_T: begin
                en_timer = 1'b1;
                w_next   = ST_WAIT;
            end
            ST_WAIT: begin
                if (timer_done) begin
                    w_next = ST_ERASE;
                end else begin
                    en_timer = 1'b1;
                    s_timer  = SEL_TMR_DEC;
                end
            end
            ST_ERASE: begin
                plot   = 1'b1;
                w_next = ST_TURN;
            end
            ST_TURN: begin
                en_direction = 1'b1;
                s_direction  = SEL_DIR_INPUT;
                w_next       = ST_MOVE;
            end
            ST_MOVE: begin
                // At a screen edge nothing is enabled, so the sprite is redrawn in place.
                case (r_dir_q)
                    DIR_UP: if (!w_at_top) begin
                        en_y_position = 1'b1;
                        s_y_position  = SEL_POS_DEC;
                    end
                    DIR_DOWN: if (!w_at_bottom) begin
                        en_y_position = 1'b1;
                        s_y_position  = SEL_POS_INC;
                    end
                    DIR_LEFT: if (!w_at_left) begin
                        en_x_position = 1'b1;
                        s_x_position  = SEL_POS_DEC;
                    end
                    default: if (!w_at_right) begin
                        en_x_position = 1'b1;
                        s_x_position  = SEL_POS_INC;
                    end
                endcase
                w_next = ST_DRAW;
            end
            default: w_next = ST_IDLE;
        endcase
    end

endmodule
